// File: rtl/scancode_player.sv
// rtl/scancode_player.sv - scripted scan-code replay engine driving the sim_data/sim_data_en injection port
// Optional make/break playback (0xF0 prefix + repeated code) is enabled by defining SCANCODE_PLAYER_BREAK_EN.
module scancode_player #(
    parameter int DEPTH           = 16,
    parameter int DATA_W          = 9,
    parameter int PULSE_CYCLES    = 1,
    parameter int GAP_CYCLES      = 4,
    parameter int LONG_GAP_CYCLES = 1000
) (
    input  logic                       CLOCK_50,
    input  logic                       reset,
    input  logic                       wr_en,
    input  logic [$clog2(DEPTH)-1:0]   wr_addr,
    input  logic [DATA_W:0]            wr_data,
    input  logic [$clog2(DEPTH):0]     count,
    input  logic                       start,
    input  logic                       loop_mode,
    input  logic                       abort,
    output logic [DATA_W-1:0]          sim_data,
    output logic                       sim_data_en,
    output logic                       busy,
    output logic                       done,
    output logic [$clog2(DEPTH)-1:0]   idx
);

    localparam int AW   = $clog2(DEPTH);
    localparam int MAXC = (PULSE_CYCLES > LONG_GAP_CYCLES) ?
                          ((PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES) :
                          ((LONG_GAP_CYCLES > GAP_CYCLES) ? LONG_GAP_CYCLES : GAP_CYCLES);
    localparam int CW   = $clog2(MAXC + 1);

    localparam logic [CW-1:0] PULSE_LAST = CW'(PULSE_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LAST   = CW'(GAP_CYCLES - 1);
    localparam logic [CW-1:0] LONG_LAST  = CW'(LONG_GAP_CYCLES - 1);
    localparam logic [AW:0]   DEPTH_C    = (AW+1)'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_EMIT     = 3'd1,
        S_GAP      = 3'd2,
        S_BRK_EMIT = 3'd3,
        S_BRK_GAP  = 3'd4
    } state_t;

    logic [DATA_W:0] mem [DEPTH];

    state_t            state_q, state_d;
    logic [AW-1:0]     idx_q, idx_d;
    logic [DATA_W-1:0] sim_data_q, sim_data_d;
    logic              sim_data_en_q, sim_data_en_d;
    logic              done_q, done_d;
    logic [CW-1:0]     pulse_cnt_q, pulse_cnt_d;
    logic [CW-1:0]     gap_cnt_q, gap_cnt_d;
    logic [AW:0]       count_q, count_d;
    logic              loop_q, loop_d;
    logic              long_q, long_d;
`ifdef SCANCODE_PLAYER_BREAK_EN
    localparam logic [DATA_W-1:0] BRK_CODE = DATA_W'(8'hF0);
    logic [DATA_W-1:0] code_q, code_d;
    logic              brk_phase_q, brk_phase_d;
`endif

    logic [AW:0]     eff_count;
    logic            pulse_done;
    logic            gap_done;
    logic            last_entry;
    logic            advance;
    logic            do_emit;
    logic [AW-1:0]   emit_idx;
    logic [DATA_W:0] rd_entry;

    always_ff @(posedge CLOCK_50) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_entry = mem[emit_idx];

    // Decide whether an entry is loaded this cycle and which one; kept apart from
    // the main next-state logic so the RAM read address settles first.
    always_comb begin
        eff_count  = (count > DEPTH_C) ? DEPTH_C : count;
        pulse_done = (pulse_cnt_q == PULSE_LAST);
        gap_done   = (gap_cnt_q == (long_q ? LONG_LAST : GAP_LAST));
        last_entry = ({1'b0, idx_q} == (count_q - 1'b1));
`ifdef SCANCODE_PLAYER_BREAK_EN
        advance    = (state_q == S_BRK_GAP) && (gap_cnt_q == GAP_LAST) && brk_phase_q;
`else
        advance    = (state_q == S_GAP) && gap_done;
`endif
        do_emit    = 1'b0;
        emit_idx   = idx_q;
        if (!abort) begin
            if (state_q == S_IDLE && start && eff_count != '0) begin
                do_emit  = 1'b1;
                emit_idx = '0;
            end else if (advance && !last_entry) begin
                do_emit  = 1'b1;
                emit_idx = idx_q + 1'b1;
            end else if (advance && loop_q) begin
                do_emit  = 1'b1;
                emit_idx = '0;
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        sim_data_d    = sim_data_q;
        sim_data_en_d = 1'b0;
        done_d        = 1'b0;
        pulse_cnt_d   = '0;
        gap_cnt_d     = '0;
        count_d       = count_q;
        loop_d        = loop_q;
        long_d        = long_q;
`ifdef SCANCODE_PLAYER_BREAK_EN
        code_d        = code_q;
        brk_phase_d   = brk_phase_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (do_emit) begin
                    count_d = eff_count;
                    loop_d  = loop_mode;
                end
            end
            S_EMIT: begin
                if (pulse_done) begin
                    state_d = S_GAP;
                end else begin
                    pulse_cnt_d   = pulse_cnt_q + 1'b1;
                    sim_data_en_d = 1'b1;
                end
            end
            S_GAP: begin
                if (!gap_done) begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                end
`ifdef SCANCODE_PLAYER_BREAK_EN
                else begin
                    state_d       = S_BRK_EMIT;
                    brk_phase_d   = 1'b0;
                    sim_data_d    = BRK_CODE;
                    sim_data_en_d = 1'b1;
                end
`else
                else if (!do_emit) begin
                    state_d = S_IDLE;
                    idx_d   = '0;
                    done_d  = 1'b1;
                end
`endif
            end
`ifdef SCANCODE_PLAYER_BREAK_EN
            S_BRK_EMIT: begin
                if (pulse_done) begin
                    state_d = S_BRK_GAP;
                end else begin
                    pulse_cnt_d   = pulse_cnt_q + 1'b1;
                    sim_data_en_d = 1'b1;
                end
            end
            S_BRK_GAP: begin
                if (gap_cnt_q != GAP_LAST) begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                end else if (!brk_phase_q) begin
                    state_d       = S_BRK_EMIT;
                    brk_phase_d   = 1'b1;
                    sim_data_d    = code_q;
                    sim_data_en_d = 1'b1;
                end else if (!do_emit) begin
                    state_d = S_IDLE;
                    idx_d   = '0;
                    done_d  = 1'b1;
                end
            end
`endif
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (do_emit) begin
            state_d       = S_EMIT;
            idx_d         = emit_idx;
            sim_data_d    = rd_entry[DATA_W-1:0];
            long_d        = rd_entry[DATA_W];
            sim_data_en_d = 1'b1;
            pulse_cnt_d   = '0;
            gap_cnt_d     = '0;
`ifdef SCANCODE_PLAYER_BREAK_EN
            code_d        = rd_entry[DATA_W-1:0];
`endif
        end

        // Abort wins over everything but reset; sim_data is deliberately left alone.
        if (abort && state_q != S_IDLE) begin
            state_d       = S_IDLE;
            idx_d         = '0;
            sim_data_en_d = 1'b0;
            done_d        = 1'b0;
            pulse_cnt_d   = '0;
            gap_cnt_d     = '0;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q       <= S_IDLE;
            idx_q         <= '0;
            sim_data_q    <= '0;
            sim_data_en_q <= 1'b0;
            done_q        <= 1'b0;
            pulse_cnt_q   <= '0;
            gap_cnt_q     <= '0;
            count_q       <= '0;
            loop_q        <= 1'b0;
            long_q        <= 1'b0;
`ifdef SCANCODE_PLAYER_BREAK_EN
            code_q        <= '0;
            brk_phase_q   <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            sim_data_q    <= sim_data_d;
            sim_data_en_q <= sim_data_en_d;
            done_q        <= done_d;
            pulse_cnt_q   <= pulse_cnt_d;
            gap_cnt_q     <= gap_cnt_d;
            count_q       <= count_d;
            loop_q        <= loop_d;
            long_q        <= long_d;
`ifdef SCANCODE_PLAYER_BREAK_EN
            code_q        <= code_d;
            brk_phase_q   <= brk_phase_d;
`endif
        end
    end

    assign sim_data    = sim_data_q;
    assign sim_data_en = sim_data_en_q;
    assign busy        = (state_q != S_IDLE);
    assign done        = done_q;
    assign idx         = idx_q;

endmodule

// File: tb/tb_scancode_player.sv
// tb/tb_scancode_player.sv - directed self-checking bench for scancode_player
module tb_scancode_player;

    localparam int DEPTH  = 16;
    localparam int DATA_W = 9;
    localparam int AW     = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              wr_en;
    logic [AW-1:0]     wr_addr;
    logic [DATA_W:0]   wr_data;
    logic [AW:0]       count;
    logic              start;
    logic              loop_mode;
    logic              abort;
    logic [DATA_W-1:0] sim_data;
    logic              sim_data_en;
    logic              busy;
    logic              done;
    logic [AW-1:0]     idx;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    int p_cyc[$];
    int p_code[$];
    int p_idx[$];
    int done_cyc[$];

    scancode_player #(
        .DEPTH(DEPTH), .DATA_W(DATA_W), .PULSE_CYCLES(1),
        .GAP_CYCLES(4), .LONG_GAP_CYCLES(1000)
    ) dut (
        .CLOCK_50(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .count(count), .start(start), .loop_mode(loop_mode),
        .abort(abort), .sim_data(sim_data), .sim_data_en(sim_data_en),
        .busy(busy), .done(done), .idx(idx)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (sim_data_en) begin
            p_cyc.push_back(cyc);
            p_code.push_back(int'(sim_data));
            p_idx.push_back(int'(idx));
        end
        if (done) done_cyc.push_back(cyc);
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_logs();
        p_cyc.delete();
        p_code.delete();
        p_idx.delete();
        done_cyc.delete();
    endtask

    task automatic wr(input int a, input int d);
        wr_addr = AW'(a);
        wr_data = (DATA_W+1)'(d);
        wr_en   = 1'b1;
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic play(input int n, input bit lp, output int s);
        count     = (AW+1)'(n);
        loop_mode = lp;
        start     = 1'b1;
        s         = cyc;
        tick();
        start     = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input string tag);
        int k = 0;
        while (busy && k < budget) begin
            tick();
            k++;
        end
        check(tag, int'(busy), 0);
    endtask

    task automatic wait_pulses(input int n, input int budget);
        int k = 0;
        while (p_cyc.size() < n && k < budget) begin
            tick();
            k++;
        end
        check("pulse_wait", (p_cyc.size() >= n) ? 1 : 0, 1);
    endtask

    initial begin
        int s;
        int k;
        reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; count = '0;
        start = 1'b0; loop_mode = 1'b0; abort = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        check("rst_sim_data", int'(sim_data), 0);
        check("rst_en", int'(sim_data_en), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_idx", int'(idx), 0);

`ifdef SCANCODE_PLAYER_BREAK_EN
        clear_logs();
        wr(0, 'h03A);
        play(1, 1'b0, s);
        wait_idle(100, "brk_idle");
        check("brk_npulse", p_cyc.size(), 3);
        check("brk_code0", (p_code.size() > 0) ? p_code[0] : -1, 'h03A);
        check("brk_code1", (p_code.size() > 1) ? p_code[1] : -1, 'h0F0);
        check("brk_code2", (p_code.size() > 2) ? p_code[2] : -1, 'h03A);
        check("brk_ndone", done_cyc.size(), 1);
        check("brk_lat", (p_cyc.size() > 0) ? p_cyc[0] - s : -1, 1);
`else
        // Basic five-entry one-shot
        wr(0, 'h032); wr(1, 'h046); wr(2, 'h046); wr(3, 'h046); wr(4, 'h05A);
        clear_logs();
        play(5, 1'b0, s);
        wait_idle(200, "t1_idle");
        check("t1_npulse", p_cyc.size(), 5);
        if (p_cyc.size() == 5) begin
            check("t1_lat", p_cyc[0] - s, 1);
            for (int i = 1; i < 5; i++) check($sformatf("t1_space%0d", i), p_cyc[i] - p_cyc[i-1], 5);
            check("t1_code0", p_code[0], 'h032);
            check("t1_code2", p_code[2], 'h046);
            check("t1_code3", p_code[3], 'h046);
            check("t1_code4", p_code[4], 'h05A);
            check("t1_done_at", (done_cyc.size() > 0) ? done_cyc[0] - p_cyc[4] : -1, 5);
        end
        check("t1_ndone", done_cyc.size(), 1);
        check("t1_hold", int'(sim_data), 'h05A);

        // Long gap after entry 2
        wr(2, 'h246);
        clear_logs();
        play(5, 1'b0, s);
        wait_idle(1300, "t2_idle");
        check("t2_npulse", p_cyc.size(), 5);
        if (p_cyc.size() == 5) begin
            check("t2_sp1", p_cyc[1] - p_cyc[0], 5);
            check("t2_sp2", p_cyc[2] - p_cyc[1], 5);
            check("t2_sp3", p_cyc[3] - p_cyc[2], 1001);
            check("t2_sp4", p_cyc[4] - p_cyc[3], 5);
        end
        wr(2, 'h046);

        // Loop of two, latched count/loop, abort mid-gap
        clear_logs();
        play(2, 1'b1, s);
        count = '0;
        loop_mode = 1'b0;
        wait_pulses(6, 100);
        tick(); tick();
        check("t3_busy_pre", int'(busy), 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("t3_abort_busy", int'(busy), 0);
        check("t3_abort_idx", int'(idx), 0);
        check("t3_abort_en", int'(sim_data_en), 0);
        check("t3_abort_data", int'(sim_data), 'h046);
        repeat (10) tick();
        check("t3_npulse", p_cyc.size(), 6);
        for (int i = 0; i < 6 && i < p_idx.size(); i++) check($sformatf("t3_idx%0d", i), p_idx[i], i % 2);
        check("t3_ndone", done_cyc.size(), 0);

        // count=0, start+abort together, start held while busy
        clear_logs();
        play(0, 1'b0, s);
        tick();
        check("t4_zero_busy", int'(busy), 0);
        check("t4_zero_done", done_cyc.size(), 0);
        count = 6'd2; start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        tick();
        check("t4_sa_busy", int'(busy), 0);
        check("t4_sa_npulse", p_cyc.size(), 0);
        count = 6'd5; loop_mode = 1'b0; start = 1'b1;
        repeat (12) tick();
        start = 1'b0;
        wait_idle(200, "t4_idle");
        check("t4_npulse", p_cyc.size(), 5);
        if (p_idx.size() == 5) check("t4_idx4", p_idx[4], 4);
        if (p_cyc.size() == 5) check("t4_sp2", p_cyc[2] - p_cyc[1], 5);

        // Rewrite entry 3 during playback
        clear_logs();
        play(5, 1'b0, s);
        k = 0;
        while (idx != 1 && k < 50) begin tick(); k++; end
        check("t5_reach_idx1", int'(idx), 1);
        wr(3, 'h029);
        wait_idle(200, "t5_idle");
        check("t5_code3", (p_code.size() > 3) ? p_code[3] : -1, 'h029);
        check("t5_code4", (p_code.size() > 4) ? p_code[4] : -1, 'h05A);

        // Reset during EMIT
        clear_logs();
        play(5, 1'b0, s);
        k = 0;
        while (!(sim_data_en && idx == 2) && k < 50) begin tick(); k++; end
        check("t6_in_emit", int'(sim_data_en), 1);
        reset = 1'b1;
        tick();
        check("t6_data", int'(sim_data), 0);
        check("t6_en", int'(sim_data_en), 0);
        check("t6_busy", int'(busy), 0);
        check("t6_done", int'(done), 0);
        check("t6_idx", int'(idx), 0);
        reset = 1'b0;
        tick();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
